lif_cfg_sequencer: RTL

- Controller placed in front of the single-channel LIF system.
- Accepts a parallel parameter set through a valid/ready handshake and serialises it onto the loader's load_mode/serial_data pins.
- Waits for the loader's params_ready, then gates the neuron's input_enable from a run request.
- Flags a sticky error when params_ready does not arrive within a timeout.

---
 rtl/lif_cfg_pkg.sv | 47 ++++
 rtl/lif_cfg_shifter.sv | 76 +++++++
 rtl/lif_cfg_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lif_cfg_pkg.sv
// ============================================================================
// Module  : lif_cfg_pkg
// Purpose : Shared types and frame layout for the LIF configuration sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lif_cfg_pkg;

    localparam int FRAME_W       = 23;

    localparam int WEIGHT_W      = 3;
    localparam int LEAK_RATE_W   = 8;
    localparam int THRESHOLD_W   = 8;
    localparam int LEAK_CYC_W    = 4;

    localparam int WEIGHT_MSB    = 22;
    localparam int LEAK_RATE_MSB = 19;
    localparam int THRESHOLD_MSB = 11;
    localparam int LEAK_CYC_MSB  = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_RDY = 2'd2,
        ACTIVE   = 2'd3
    } state_e;

    // Loader expects weight first, leak_cycles last, MSB first within each field.
    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [WEIGHT_W-1:0]    weight,
        input logic [LEAK_RATE_W-1:0] leak_rate,
        input logic [THRESHOLD_W-1:0] threshold,
        input logic [LEAK_CYC_W-1:0]  leak_cycles
    );
        logic [FRAME_W-1:0] f;
        f = '0;
        f[WEIGHT_MSB    -: WEIGHT_W]    = weight;
        f[LEAK_RATE_MSB -: LEAK_RATE_W] = leak_rate;
        f[THRESHOLD_MSB -: THRESHOLD_W] = threshold;
        f[LEAK_CYC_MSB  -: LEAK_CYC_W]  = leak_cycles;
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lif_cfg_shifter.sv
// ============================================================================
// Module  : lif_cfg_shifter
// Purpose : Parallel-load, MSB-first shift register with bit counter and done.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_cfg_shifter
    import lif_cfg_pkg::*;
#(
    parameter int WIDTH = FRAME_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] frame_in,
    output logic             serial_out,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] sreg_q,   sreg_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             active_q, active_d;
    logic             serial_q, serial_d;
    logic             w_last;

    assign w_last     = active_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign serial_out = serial_q;
    assign done       = w_last;

    // The first bit is presented straight from the load, so sreg only keeps the remainder.
    always_comb begin
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        serial_d = serial_q;
        if (enable) begin
            if (load) begin
                sreg_d   = frame_in << 1;
                serial_d = frame_in[WIDTH-1];
                cnt_d    = '0;
                active_d = 1'b1;
            end else if (active_q) begin
                if (w_last) begin
                    serial_d = 1'b0;
                    active_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    serial_d = sreg_q[WIDTH-1];
                    sreg_d   = sreg_q << 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            serial_q <= 1'b0;
        end else begin
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            serial_q <= serial_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lif_cfg_sequencer.sv
// ============================================================================
// Module  : lif_cfg_sequencer
// Purpose : Serialises a parameter set to the LIF loader and gates neuron runs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_cfg_sequencer
    import lif_cfg_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int FRAME_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [WEIGHT_W-1:0]    cfg_weight,
    input  logic [LEAK_RATE_W-1:0] cfg_leak_rate,
    input  logic [THRESHOLD_W-1:0] cfg_threshold,
    input  logic [LEAK_CYC_W-1:0]  cfg_leak_cycles,
    input  logic                   run_req,
    input  logic                   params_ready_in,
    output logic                   load_mode,
    output logic                   serial_data,
    output logic                   input_enable,
    output logic                   busy,
    output logic                   cfg_error
);

    state_e       state_q,        state_d;
    logic [7:0]   tmo_q,          tmo_d;
    logic         load_mode_q,    load_mode_d;
    logic         input_enable_q, input_enable_d;
    logic         cfg_error_q,    cfg_error_d;

    logic               w_accept;
    logic               w_shift_done;
    logic [FRAME_W-1:0] w_frame;

    assign cfg_ready    = (state_q == IDLE) || (state_q == ACTIVE);
    assign busy         = (state_q == SHIFT) || (state_q == WAIT_RDY);
    assign w_accept     = enable && cfg_valid && cfg_ready;
    assign w_frame      = pack_frame(cfg_weight, cfg_leak_rate, cfg_threshold, cfg_leak_cycles);

    assign load_mode    = load_mode_q;
    assign input_enable = input_enable_q;
    assign cfg_error    = cfg_error_q;

    lif_cfg_shifter #(
        .WIDTH      (FRAME_W)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (w_accept),
        .frame_in   (w_frame),
        .serial_out (serial_data),
        .done       (w_shift_done)
    );

    always_comb begin
        state_d        = state_q;
        tmo_d          = tmo_q;
        load_mode_d    = load_mode_q;
        input_enable_d = input_enable_q;
        cfg_error_d    = cfg_error_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    input_enable_d = 1'b0;
                    if (w_accept) begin
                        state_d     = SHIFT;
                        load_mode_d = 1'b1;
                        cfg_error_d = 1'b0;
                    end
                end
                SHIFT: begin
                    input_enable_d = 1'b0;
                    if (w_shift_done) begin
                        state_d     = WAIT_RDY;
                        load_mode_d = 1'b0;
                        tmo_d       = '0;
                    end
                end
                WAIT_RDY: begin
                    if (params_ready_in) begin
                        state_d = ACTIVE;
                        tmo_d   = '0;
                    end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                        state_d     = IDLE;
                        cfg_error_d = 1'b1;
                        tmo_d       = '0;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
                ACTIVE: begin
                    // A new parameter set outranks a simultaneous loss of params_ready.
                    if (w_accept) begin
                        state_d        = SHIFT;
                        load_mode_d    = 1'b1;
                        input_enable_d = 1'b0;
                        cfg_error_d    = 1'b0;
                    end else if (!params_ready_in) begin
                        state_d        = IDLE;
                        input_enable_d = 1'b0;
                    end else begin
                        input_enable_d = run_req;
                    end
                end
                default: begin
                    state_d        = IDLE;
                    load_mode_d    = 1'b0;
                    input_enable_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            tmo_q          <= '0;
            load_mode_q    <= 1'b0;
            input_enable_q <= 1'b0;
            cfg_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            load_mode_q    <= load_mode_d;
            input_enable_q <= input_enable_d;
            cfg_error_q    <= cfg_error_d;
        end
    end

endmodule

`default_nettype wire
